// File: rtl/n64_pkg.sv
// Shared definitions for the N64 single-wire host poller.
// Contents: command byte constants, reply lengths, the host FSM state enum,
// and helpers that derive bit-cell timing from the clock-cycles-per-us value.
package n64_pkg;

  localparam logic [7:0] CMD_STATUS = 8'h00;
  localparam logic [7:0] CMD_POLL   = 8'h01;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  localparam logic [5:0] REPLY_LEN_SHORT = 6'd24;
  localparam logic [5:0] REPLY_LEN_LONG  = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_BIT,
    ST_TX_STOP,
    ST_RX_WAIT,
    ST_RX_SAMPLE,
    ST_RX_STOP,
    ST_DONE,
    ST_ERR
  } state_e;

  // Bit-cell timing as a function of clock cycles per microsecond.
  function automatic int unsigned bit_cyc(input int unsigned us_cyc);
    return 4 * us_cyc;
  endfunction

  function automatic int unsigned short_cyc(input int unsigned us_cyc);
    return us_cyc;
  endfunction

  function automatic int unsigned long_cyc(input int unsigned us_cyc);
    return 3 * us_cyc;
  endfunction

  function automatic int unsigned sample_cyc(input int unsigned us_cyc);
    return 2 * us_cyc;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Constants for the 12 MHz board clock.
  localparam int unsigned DEF_US_CYC = 12;
  localparam int unsigned BIT_CYC    = bit_cyc(DEF_US_CYC);
  localparam int unsigned SHORT_CYC  = short_cyc(DEF_US_CYC);
  localparam int unsigned LONG_CYC   = long_cyc(DEF_US_CYC);
  localparam int unsigned SAMPLE_CYC = sample_cyc(DEF_US_CYC);

  // Expected reply length for a command; 0 marks an unsupported command.
  function automatic logic [5:0] reply_len(input logic [7:0] cmd);
    case (cmd)
      CMD_STATUS, CMD_RESET: return REPLY_LEN_SHORT;
      CMD_POLL:              return REPLY_LEN_LONG;
      default:               return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/n64_host_poller_if.sv
// Request/response and line signals of the N64 host poller.
//   start      : one-cycle transaction request
//   cmd        : command byte, sampled on the accepted start cycle
//   line_in    : raw bus level, asynchronous to clk
//   drive_low  : 1 = pull the line low, 0 = release
//   busy       : transaction in progress
//   resp_data  : last good reply, right-aligned
//   resp_valid : one-cycle pulse, resp_data updated
//   resp_err   : one-cycle pulse, transaction failed
// The slave modport is the poller; master is the requester / line side.
interface n64_host_poller_if;
  logic        start;
  logic [7:0]  cmd;
  logic        line_in;
  logic        drive_low;
  logic        busy;
  logic [31:0] resp_data;
  logic        resp_valid;
  logic        resp_err;

  modport master (
    output start, cmd, line_in,
    input  drive_low, busy, resp_data, resp_valid, resp_err
  );

  modport slave (
    input  start, cmd, line_in,
    output drive_low, busy, resp_data, resp_valid, resp_err
  );
endinterface

// File: rtl/n64_line_sync.sv
// Two-flop synchronizer for the raw N64 bus level plus falling-edge detect.
//   clk, rst_n : clock, asynchronous active-low reset
//   line_in    : raw asynchronous bus level
//   line_s     : synchronized level
//   fall       : one-cycle pulse when line_s goes 1 -> 0
// Flops reset to 1 (idle bus level) so reset release never fakes an edge.
module n64_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic line_s,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign line_s = sync_q;
  assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/n64_host_poller.sv
// Console-side initiator for the N64 single-wire bus.
// Sends one command byte with open-drain pulse coding (0 = 3us low/1us high,
// 1 = 1us low/3us high, then a 1us low stop), then decodes the 24- or 32-bit
// controller reply by sampling 2us after each falling edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of n64_host_poller_if (start/cmd request,
//                line_in/drive_low line, busy/resp_* result)
// Parameters: US_CYC clocks per us, RESP_TIMEOUT_US first-reply limit,
// BIT_TIMEOUT_US limit between successive reply falling edges.
module n64_host_poller
  import n64_pkg::*;
#(
  parameter int unsigned US_CYC          = 12,
  parameter int unsigned RESP_TIMEOUT_US = 64,
  parameter int unsigned BIT_TIMEOUT_US  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  n64_host_poller_if.slave bus
);

  localparam int unsigned BIT_C    = bit_cyc(US_CYC);
  localparam int unsigned SHORT_C  = short_cyc(US_CYC);
  localparam int unsigned LONG_C   = long_cyc(US_CYC);
  localparam int unsigned SAMPLE_C = sample_cyc(US_CYC);
  localparam int unsigned RESP_C   = RESP_TIMEOUT_US * US_CYC;
  localparam int unsigned BITTO_C  = BIT_TIMEOUT_US * US_CYC;
  localparam int unsigned CNT_MAX  = max_u(max_u(RESP_C, BITTO_C), BIT_C);
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] K_BIT_LAST   = CNT_W'(BIT_C - 1);
  localparam logic [CNT_W-1:0] K_SHORT      = CNT_W'(SHORT_C);
  localparam logic [CNT_W-1:0] K_SHORT_LAST = CNT_W'(SHORT_C - 1);
  localparam logic [CNT_W-1:0] K_LONG       = CNT_W'(LONG_C);
  localparam logic [CNT_W-1:0] K_SAMPLE     = CNT_W'(SAMPLE_C);
  localparam logic [CNT_W-1:0] K_RESP_LAST  = CNT_W'(RESP_C - 1);
  localparam logic [CNT_W-1:0] K_BITTO_LAST = CNT_W'(BITTO_C - 1);

  logic line_s;
  logic fall;

  n64_line_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (bus.line_in),
    .line_s  (line_s),
    .fall    (fall)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [7:0]        tx_sr_q, tx_sr_d;
  logic [5:0]        bit_q, bit_d;
  logic [5:0]        rx_len_q, rx_len_d;
  logic [31:0]       shadow_q, shadow_d;
  logic [31:0]       data_q, data_d;
  logic              stop_seen_q, stop_seen_d;
  logic              drive_q, drive_d;
  logic [5:0]        start_len;

  // Saturating increment: long idle periods must never wrap into a
  // spurious "in time" reading.
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign start_len = reply_len(bus.cmd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tx_sr_q     <= '0;
      bit_q       <= '0;
      rx_len_q    <= '0;
      shadow_q    <= '0;
      data_q      <= '0;
      stop_seen_q <= 1'b0;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_sr_q     <= tx_sr_d;
      bit_q       <= bit_d;
      rx_len_q    <= rx_len_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      stop_seen_q <= stop_seen_d;
      drive_q     <= drive_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    tx_sr_d     = tx_sr_q;
    bit_d       = bit_q;
    rx_len_d    = rx_len_q;
    shadow_d    = shadow_q;
    data_d      = data_q;
    stop_seen_d = stop_seen_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          if (start_len == 6'd0 || !line_s) begin
            state_d = ST_ERR;
          end else begin
            state_d     = ST_TX_BIT;
            tx_sr_d     = bus.cmd;
            bit_d       = '0;
            rx_len_d    = start_len;
            shadow_d    = '0;
            stop_seen_d = 1'b0;
          end
        end
      end

      ST_TX_BIT: begin
        if (cnt_q == K_BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == 6'd7) begin
            state_d = ST_TX_STOP;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + 6'd1;
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end
      end

      ST_TX_STOP: begin
        if (cnt_q == K_SHORT_LAST) begin
          cnt_d   = '0;
          state_d = ST_RX_WAIT;
        end
      end

      // From here on cnt_q counts cycles since the last detected reply
      // edge (or since release for the first bit), so the sample point
      // and the inter-edge timeout share one timer.
      ST_RX_WAIT: begin
        if (fall) begin
          state_d = ST_RX_SAMPLE;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q >= ((bit_q == 6'd0) ? K_RESP_LAST : K_BITTO_LAST)) begin
          state_d = ST_ERR;
        end
      end

      ST_RX_SAMPLE: begin
        if (cnt_q == K_SAMPLE) begin
          shadow_d = {shadow_q[30:0], line_s};
          bit_d    = bit_q + 6'd1;
          state_d  = (bit_q + 6'd1 == rx_len_q) ? ST_RX_STOP : ST_RX_WAIT;
        end
      end

      ST_RX_STOP: begin
        if (!stop_seen_q) begin
          if (fall) begin
            stop_seen_d = 1'b1;
            cnt_d       = CNT_W'(1);
          end else if (cnt_q >= K_BITTO_LAST) begin
            state_d = ST_ERR;
          end
        end else if (line_s) begin
          state_d = ST_DONE;
          data_d  = shadow_q;
        end else if (cnt_q >= K_LONG) begin
          state_d = ST_ERR;
        end
      end

      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // drive_low is registered from the next-state values so the open-drain
  // enable never glitches on counter decode.
  always_comb begin
    drive_d = 1'b0;
    if (state_d == ST_TX_BIT) begin
      drive_d = cnt_d < (tx_sr_d[7] ? K_SHORT : K_LONG);
    end else if (state_d == ST_TX_STOP) begin
      drive_d = cnt_d < K_SHORT;
    end
  end

  assign bus.drive_low  = drive_q;
  assign bus.busy       = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign bus.resp_valid = (state_q == ST_DONE);
  assign bus.resp_err   = (state_q == ST_ERR);
  assign bus.resp_data  = data_q;

endmodule

// File: tb/tb_n64_host_poller.sv
// Self-checking bench for n64_host_poller: a behavioural controller model on
// the wired-AND line, a drive_low pulse recorder, and an expected-result queue
// popped when the poller reports valid/err.
module tb_n64_host_poller;

  localparam int US     = 12;
  localparam int RESP_L = 64 * US;
  localparam int BITO_L = 8 * US;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ctrl_low = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t exp_q[$];
  int   tx_runs[$];
  int   run_len = 0;
  int   rel_cyc = 0;
  int   last_fall_cyc = 0;
  bit   dl_seen = 1'b0;

  n64_host_poller_if bus ();

  assign bus.line_in = ~(bus.drive_low | ctrl_low);

  n64_host_poller #(
    .US_CYC          (12),
    .RESP_TIMEOUT_US (64),
    .BIT_TIMEOUT_US  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Record drive_low low-pulse lengths; rel_cyc marks the latest release.
  always @(negedge clk) begin
    if (bus.drive_low === 1'b1) begin
      run_len++;
      dl_seen = 1'b1;
    end else if (run_len != 0) begin
      tx_runs.push_back(run_len);
      rel_cyc = cyc;
      run_len = 0;
    end
  end

  task automatic do_start(input logic [7:0] c);
    @(negedge clk);
    tx_runs.delete();
    bus.cmd   = c;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got, output bit v,
                           output bit e, output logic [31:0] d, output int n,
                           output int at);
    got = 1'b0; v = 1'b0; e = 1'b0; d = '0; n = 0; at = 0;
    while (n < budget && !got) begin
      @(negedge clk);
      n++;
      if (bus.resp_valid || bus.resp_err) begin
        got = 1'b1;
        v   = bus.resp_valid;
        e   = bus.resp_err;
        d   = bus.resp_data;
        at  = cyc;
      end
    end
  endtask

  task automatic wait_tx(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 2000 && !ok) begin
      @(negedge clk);
      n++;
      if (tx_runs.size() >= 9) ok = 1'b1;
    end
  endtask

  // Controller model: 2us turnaround, then nsend data bits, optional stop.
  task automatic ctrl_reply(input logic [31:0] data, input int nbits,
                            input int nsend, input bit stop);
    logic [31:0] dv;
    bit b;
    dv = data;
    repeat (2 * US) @(negedge clk);
    for (int i = 0; i < nsend; i++) begin
      b = dv[nbits - 1 - i];
      ctrl_low = 1'b1;
      last_fall_cyc = cyc;
      repeat (b ? US : 3 * US) @(negedge clk);
      ctrl_low = 1'b0;
      repeat (b ? 3 * US : US) @(negedge clk);
    end
    if (stop) begin
      ctrl_low = 1'b1;
      repeat (US) @(negedge clk);
      ctrl_low = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.drive_low !== 1'b0) begin failures++; $display("FAIL reset_drive_low got=%b exp=0", bus.drive_low); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.resp_data !== 32'h0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", bus.resp_data); end
    checks++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", bus.resp_valid, bus.resp_err); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_txn(input string name, input logic [7:0] c,
                          input logic [31:0] reply, input int nbits,
                          input bit chk_busy);
    bit got, v, e, ok;
    logic [31:0] d;
    int n, at;
    exp_t x;
    exp_q.push_back('{1'b0, reply});
    do_start(c);
    fork
      begin
        wait_tx(ok);
        if (ok) ctrl_reply(reply, nbits, nbits, 1'b1);
      end
      wait_done(4000, got, v, e, d, n, at);
    join
    x = exp_q.pop_front();
    checks++; if (!got || !ok) begin failures++; $display("FAIL %s_timeout got=%b tx_ok=%b exp=1", name, got, ok); end
    checks++; if (v !== 1'b1 || e !== 1'b0) begin failures++; $display("FAIL %s_status valid=%b err=%b exp valid=1 err=0", name, v, e); end
    checks++; if (d !== x.data) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, d, x.data); end
    checks++; if (tx_runs.size() != 9) begin failures++; $display("FAIL %s_tx_count got=%0d exp=9", name, tx_runs.size()); end
    for (int i = 0; i < 9 && i < tx_runs.size(); i++) begin
      int want;
      want = (i == 8) ? US : (c[7 - i] ? US : 3 * US);
      checks++; if (tx_runs[i] != want) begin failures++; $display("FAIL %s_tx_pulse%0d got=%0d exp=%0d", name, i, tx_runs[i], want); end
    end
    if (chk_busy) begin
      checks++; if (n < 133 * US - 2 * US || n > 133 * US + 4 * US) begin failures++; $display("FAIL %s_busy_len got=%0d exp=%0d..%0d", name, n, 131 * US, 137 * US); end
    end
    @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL %s_after valid=%b busy=%b exp=0 0", name, bus.resp_valid, bus.busy); end
  endtask

  task automatic test_no_controller();
    bit got, v, e;
    logic [31:0] d;
    int n, at;
    exp_t x;
    exp_q.push_back('{1'b1, 32'h0005_0002});
    do_start(8'h01);
    wait_done(3000, got, v, e, d, n, at);
    x = exp_q.pop_front();
    checks++; if (!got || e !== x.is_err || v !== 1'b0) begin failures++; $display("FAIL noctrl_err got=%b err=%b valid=%b exp err=1", got, e, v); end
    checks++; if (bus.resp_data !== x.data) begin failures++; $display("FAIL noctrl_data got=%h exp=%h", bus.resp_data, x.data); end
    checks++; if (at - rel_cyc != RESP_L) begin failures++; $display("FAIL noctrl_timeout got=%0d exp=%0d", at - rel_cyc, RESP_L); end
  endtask

  task automatic test_truncated();
    bit got, v, e, ok;
    logic [31:0] d;
    int n, at;
    exp_t x;
    exp_q.push_back('{1'b1, 32'h0005_0002});
    do_start(8'h01);
    fork
      begin
        wait_tx(ok);
        if (ok) ctrl_reply(32'hA5C3_0F96, 32, 17, 1'b0);
      end
      wait_done(4000, got, v, e, d, n, at);
    join
    x = exp_q.pop_front();
    checks++; if (!got || e !== 1'b1 || v !== 1'b0) begin failures++; $display("FAIL trunc_err got=%b err=%b valid=%b exp err=1", got, e, v); end
    checks++; if (bus.resp_data !== x.data) begin failures++; $display("FAIL trunc_data got=%h exp=%h", bus.resp_data, x.data); end
    checks++; if (at - last_fall_cyc < BITO_L || at - last_fall_cyc > BITO_L + 4) begin failures++; $display("FAIL trunc_timeout got=%0d exp=%0d..%0d", at - last_fall_cyc, BITO_L, BITO_L + 4); end
    test_txn("after_trunc", 8'h01, 32'h1234_5678, 32, 1'b0);
  endtask

  task automatic test_bad_start();
    bit got, v, e;
    logic [31:0] d;
    int n, at;
    dl_seen = 1'b0;
    do_start(8'h02);
    wait_done(5, got, v, e, d, n, at);
    checks++; if (!got || e !== 1'b1 || n != 1) begin failures++; $display("FAIL badcmd_err got=%b err=%b cycles=%0d exp err=1 cycles=1", got, e, n); end
    ctrl_low = 1'b1;
    repeat (4) @(negedge clk);
    do_start(8'h01);
    wait_done(5, got, v, e, d, n, at);
    checks++; if (!got || e !== 1'b1 || n != 1) begin failures++; $display("FAIL stuck_err got=%b err=%b cycles=%0d exp err=1 cycles=1", got, e, n); end
    repeat (20) @(negedge clk);
    ctrl_low = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (dl_seen !== 1'b0) begin failures++; $display("FAIL badstart_drive got=%b exp=0", dl_seen); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_start(8'h01);
    repeat (3 * 4 * US + 9) @(negedge clk);
    checks++; if (bus.drive_low !== 1'b1) begin failures++; $display("FAIL midtx_pre_drive got=%b exp=1", bus.drive_low); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.drive_low !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL midtx_reset drive=%b busy=%b exp=0 0", bus.drive_low, bus.busy); end
    checks++; if (bus.resp_data !== 32'h0) begin failures++; $display("FAIL midtx_data got=%h exp=0", bus.resp_data); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    do_start(8'h01);
    repeat (20) @(negedge clk);
    bus.cmd = 8'h02;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.resp_err !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL busy_start err=%b busy=%b exp=0 1", bus.resp_err, bus.busy); end
    wait_tx(ok);
    if (ok) ctrl_reply(32'hFFFF_0000, 32, 20, 1'b0);
    checks++; if (!ok || bus.busy !== 1'b1 || bus.drive_low !== 1'b0) begin failures++; $display("FAIL midrx_pre tx_ok=%b busy=%b drive=%b exp=1 1 0", ok, bus.busy, bus.drive_low); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.drive_low !== 1'b0 || bus.busy !== 1'b0 || bus.resp_data !== 32'h0) begin failures++; $display("FAIL midrx_reset drive=%b busy=%b data=%h exp=0 0 0", bus.drive_low, bus.busy, bus.resp_data); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.cmd   = 8'h00;
    test_reset();
    test_txn("poll", 8'h01, 32'h8000_7F81, 32, 1'b0);
    test_txn("status", 8'h00, 32'h0005_0002, 24, 1'b1);
    test_no_controller();
    test_truncated();
    test_bad_start();
    test_reset_mid();
    test_txn("back2back_a", 8'hFF, 32'h00C3_5A01, 24, 1'b0);
    test_txn("back2back_b", 8'h01, 32'h7E00_81FF, 32, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog sim_time_exceeded");
    $fatal(1);
  end

endmodule
